game_master_fsm_rounds: RTL and testbench
=========================================

Name: game_master_fsm_rounds

Overview:
Parametrised successor of the single-shot game master. Runs a multi-round torpedo game: several torpedoes per round, a saturating score, and a life counter that ends the game at zero. It sits between the key input, the target/torpedo sprite launchers, the collision detector and the end-of-round timer. It drives sprite write strobes and round/game status to the display and LED logic.

Parameters:
SHOTS_PER_ROUND, 3, torpedoes available per round (>=1)
LIVES, 3, rounds that may be lost before game over (>=1)
SCORE_W, 8, score counter width; score saturates at 2^SCORE_W-1
SHOT_W, 2, width of shots_left; must hold SHOTS_PER_ROUND
LIFE_W, 2, width of lives; must hold LIVES

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key  in  1  fire/restart button, level, already debounced
sprite_target_write  out  1  one-cycle pulse: (re)launch target sprite
sprite_torpedo_write  out  1  one-cycle pulse: launch torpedo sprite
sprite_target_out_of_screen  in  1  target has left visible area
sprite_torpedo_out_of_screen  in  1  torpedo has left visible area
collision  in  1  torpedo/target overlap this cycle
end_of_game_timer_start  out  1  one-cycle pulse: start end-of-round timer
end_of_game_timer_running  in  1  timer busy
round_won  out  1  high during ROUND_WON
round_lost  out  1  high during ROUND_LOST
game_over  out  1  high during GAME_OVER
score  out  SCORE_W  rounds won since game start
lives  out  LIFE_W  remaining lives
shots_left  out  SHOT_W  torpedoes left in current round

Behaviour:
- Synchronous active-high reset. State goes to START_TARGET. score=0, lives=LIVES, shots_left=SHOTS_PER_ROUND. All pulse and status outputs are 0.
- key_fire is the rising edge of key: one register plus an AND. key held high counts as one press only.
- One-hot states and transitions, evaluated each clk:
  - START_TARGET: target_write=1; shots_left<=SHOTS_PER_ROUND; -> WAIT_KEY.
  - WAIT_KEY: target_out_of_screen -> START_END_TIMER (lost). Else key_fire -> START_TORPEDO. Else stay.
  - START_TORPEDO: torpedo_write=1; shots_left decrements; -> WAIT_RESULT.
  - WAIT_RESULT: collision -> START_END_TIMER (won). Else target_out_of_screen -> START_END_TIMER (lost). Else torpedo_out_of_screen -> WAIT_KEY if shots_left!=0, otherwise START_END_TIMER (lost). Else stay.
  - START_END_TIMER: timer_start=1; -> ROUND_WON or ROUND_LOST per the latched outcome flag.
  - ROUND_WON / ROUND_LOST: exit on a falling edge of end_of_game_timer_running (registered copy is 1, current is 0). Running is ignored in the entry cycle. ROUND_WON -> START_TARGET. ROUND_LOST -> GAME_OVER if lives==0 after decrement, else START_TARGET.
  - GAME_OVER: key_fire -> score<=0, lives<=LIVES, -> START_TARGET.
- Outcome flag is set on the transition into START_END_TIMER: 1 = won, 0 = lost.
- Simultaneous events in WAIT_RESULT: collision has priority over any out-of-screen signal, so a collision on the cycle the target exits is a win.
- score increments by 1 on entry to ROUND_WON and saturates at all-ones; no wrap.
- lives decrements by 1 on entry to ROUND_LOST and never goes below 0.
- Only one torpedo is in flight at a time. key_fire in WAIT_RESULT, START_* or result states is discarded, not queued.
- Reset mid-round (any state) restores the reset values the next cycle. No pulse output may be high in that cycle.
- Illegal or zero state vector recovers to START_TARGET.
- Outputs are decoded from state/counter registers. No combinational path from inputs to outputs.

Decomposition:
- Shared package game_pkg holds the state index localparams (STATE_START_TARGET … STATE_GAME_OVER) and the default SHOTS_PER_ROUND/LIVES constants, so the display and LED blocks decode the same states.
- One natural sub-module, game_edge_detect: rising/falling edge of a level with synchronous reset. It is instanced twice, for key rise and timer fall.

Test Plan:
- Reset then key press at cycle 10, collision 20 cycles later -> one target_write after reset, torpedo_write once, timer_start once, round_won high, score=1 after timer falls, lives=3.
- Three torpedoes each exit screen with no collision -> shots_left 2,1,0; round_lost; lives=2; new target_write after timer falls.
- Lose 3 rounds -> lives=0, game_over high, key ignored until rising edge; key press -> score=0, lives=3, target_write pulse.
- Collision and target_out_of_screen in the same cycle -> round_won, score increments.
- SCORE_W=2, win 5 rounds -> score sequence 1,2,3,3,3 (saturation).
- Key held high for 100 cycles, and reset asserted while in WAIT_RESULT -> exactly one torpedo_write; on reset all outputs at reset values the next cycle, no spurious pulses.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared state indices, one-hot state type and default game sizes.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int STATE_NUM = 8;

  localparam int STATE_START_TARGET    = 0;
  localparam int STATE_WAIT_KEY        = 1;
  localparam int STATE_START_TORPEDO   = 2;
  localparam int STATE_WAIT_RESULT     = 3;
  localparam int STATE_START_END_TIMER = 4;
  localparam int STATE_ROUND_WON       = 5;
  localparam int STATE_ROUND_LOST      = 6;
  localparam int STATE_GAME_OVER       = 7;

  localparam int DEFAULT_SHOTS_PER_ROUND = 3;
  localparam int DEFAULT_LIVES           = 3;

  typedef enum logic [STATE_NUM-1:0] {
    ST_START_TARGET    = 8'(1 << STATE_START_TARGET),
    ST_WAIT_KEY        = 8'(1 << STATE_WAIT_KEY),
    ST_START_TORPEDO   = 8'(1 << STATE_START_TORPEDO),
    ST_WAIT_RESULT     = 8'(1 << STATE_WAIT_RESULT),
    ST_START_END_TIMER = 8'(1 << STATE_START_END_TIMER),
    ST_ROUND_WON       = 8'(1 << STATE_ROUND_WON),
    ST_ROUND_LOST      = 8'(1 << STATE_ROUND_LOST),
    ST_GAME_OVER       = 8'(1 << STATE_GAME_OVER)
  } state_t;

endpackage
`default_nettype wire

// File: rtl/game_master_fsm_rounds_if.sv
`default_nettype none
// ============================================================================
// Module   : game_master_fsm_rounds_if
// Brief    : Game master bus: key, sprite strobes, collision, timer, status.
// Revision : 1.0 - initial release
// ============================================================================
interface game_master_fsm_rounds_if #(
  parameter int SCORE_W = 8,
  parameter int SHOT_W  = 2,
  parameter int LIFE_W  = 2
) ();

  logic               key;
  logic               sprite_target_write;
  logic               sprite_torpedo_write;
  logic               sprite_target_out_of_screen;
  logic               sprite_torpedo_out_of_screen;
  logic               collision;
  logic               end_of_game_timer_start;
  logic               end_of_game_timer_running;
  logic               round_won;
  logic               round_lost;
  logic               game_over;
  logic [SCORE_W-1:0] score;
  logic [LIFE_W-1:0]  lives;
  logic [SHOT_W-1:0]  shots_left;

  modport master (
    input  key, sprite_target_out_of_screen, sprite_torpedo_out_of_screen,
           collision, end_of_game_timer_running,
    output sprite_target_write, sprite_torpedo_write, end_of_game_timer_start,
           round_won, round_lost, game_over, score, lives, shots_left
  );

  modport slave (
    output key, sprite_target_out_of_screen, sprite_torpedo_out_of_screen,
           collision, end_of_game_timer_running,
    input  sprite_target_write, sprite_torpedo_write, end_of_game_timer_start,
           round_won, round_lost, game_over, score, lives, shots_left
  );

endinterface
`default_nettype wire

// File: rtl/game_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : game_edge_detect
// Brief    : Single-register rising or falling edge detector on a level.
// Revision : 1.0 - initial release
// ============================================================================
module game_edge_detect #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  generate
    if (RISING) begin : g_rise
      assign pulse = level & ~level_q;
    end else begin : g_fall
      assign pulse = ~level & level_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/game_master_fsm_rounds.sv
`default_nettype none
// ============================================================================
// Module   : game_master_fsm_rounds
// Brief    : Multi-round torpedo game master with saturating score and lives.
// Revision : 1.0 - initial release
// ============================================================================
module game_master_fsm_rounds
  import game_pkg::*;
#(
  parameter int SHOTS_PER_ROUND = DEFAULT_SHOTS_PER_ROUND,
  parameter int LIVES           = DEFAULT_LIVES,
  parameter int SCORE_W         = 8,
  parameter int SHOT_W          = 2,
  parameter int LIFE_W          = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  game_master_fsm_rounds_if.master  bus
);

  state_t             state;
  logic [SCORE_W-1:0] score;
  logic [LIFE_W-1:0]  lives;
  logic [SHOT_W-1:0]  shots_left;
  logic               target_write;
  logic               torpedo_write;
  logic               timer_start;
  logic               won;
  logic               result_entry;
  logic               key_fire;
  logic               timer_fall;

  game_edge_detect #(.RISING(1'b1)) u_key_rise (
    .clk   (clk),
    .reset (reset),
    .level (bus.key),
    .pulse (key_fire)
  );

  game_edge_detect #(.RISING(1'b0)) u_timer_fall (
    .clk   (clk),
    .reset (reset),
    .level (bus.end_of_game_timer_running),
    .pulse (timer_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_START_TARGET;
      score         <= '0;
      lives         <= LIFE_W'(LIVES);
      shots_left    <= SHOT_W'(SHOTS_PER_ROUND);
      target_write  <= 1'b0;
      torpedo_write <= 1'b0;
      timer_start   <= 1'b0;
      won           <= 1'b0;
      result_entry  <= 1'b0;
    end else begin
      target_write  <= 1'b0;
      torpedo_write <= 1'b0;
      timer_start   <= 1'b0;
      result_entry  <= 1'b0;
      case (state)
        ST_START_TARGET: begin
          target_write <= 1'b1;
          shots_left   <= SHOT_W'(SHOTS_PER_ROUND);
          state        <= ST_WAIT_KEY;
        end
        ST_WAIT_KEY: begin
          if (bus.sprite_target_out_of_screen) begin
            won   <= 1'b0;
            state <= ST_START_END_TIMER;
          end else if (key_fire) begin
            state <= ST_START_TORPEDO;
          end
        end
        ST_START_TORPEDO: begin
          torpedo_write <= 1'b1;
          if (shots_left != '0) begin
            shots_left <= shots_left - 1'b1;
          end
          state <= ST_WAIT_RESULT;
        end
        // Collision outranks both out-of-screen events.
        ST_WAIT_RESULT: begin
          if (bus.collision) begin
            won   <= 1'b1;
            state <= ST_START_END_TIMER;
          end else if (bus.sprite_target_out_of_screen) begin
            won   <= 1'b0;
            state <= ST_START_END_TIMER;
          end else if (bus.sprite_torpedo_out_of_screen) begin
            if (shots_left != '0) begin
              state <= ST_WAIT_KEY;
            end else begin
              won   <= 1'b0;
              state <= ST_START_END_TIMER;
            end
          end
        end
        ST_START_END_TIMER: begin
          timer_start  <= 1'b1;
          result_entry <= 1'b1;
          if (won) begin
            if (score != '1) begin
              score <= score + 1'b1;
            end
            state <= ST_ROUND_WON;
          end else begin
            if (lives != '0) begin
              lives <= lives - 1'b1;
            end
            state <= ST_ROUND_LOST;
          end
        end
        ST_ROUND_WON: begin
          if (!result_entry && timer_fall) begin
            state <= ST_START_TARGET;
          end
        end
        ST_ROUND_LOST: begin
          if (!result_entry && timer_fall) begin
            state <= (lives == '0) ? ST_GAME_OVER : ST_START_TARGET;
          end
        end
        ST_GAME_OVER: begin
          if (key_fire) begin
            score <= '0;
            lives <= LIFE_W'(LIVES);
            state <= ST_START_TARGET;
          end
        end
        default: state <= ST_START_TARGET;
      endcase
    end
  end

  assign bus.sprite_target_write     = target_write;
  assign bus.sprite_torpedo_write    = torpedo_write;
  assign bus.end_of_game_timer_start = timer_start;
  assign bus.round_won               = state[STATE_ROUND_WON];
  assign bus.round_lost              = state[STATE_ROUND_LOST];
  assign bus.game_over               = state[STATE_GAME_OVER];
  assign bus.score                   = score;
  assign bus.lives                   = lives;
  assign bus.shots_left              = shots_left;

endmodule
`default_nettype wire

// File: tb/tb_game_master_fsm_rounds.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_master_fsm_rounds
// Brief    : Directed self-checking bench for the multi-round game master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_master_fsm_rounds;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  game_master_fsm_rounds_if #(.SCORE_W(2), .SHOT_W(2), .LIFE_W(2)) bus ();

  game_master_fsm_rounds #(
    .SHOTS_PER_ROUND (3),
    .LIVES           (3),
    .SCORE_W         (2),
    .SHOT_W          (2),
    .LIFE_W          (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cnt_tgt = 0;
  int cnt_torp = 0;
  int cnt_tmr = 0;
  int c_tgt, c_torp, c_tmr;

  always @(posedge clk) begin
    #1;
    if (bus.sprite_target_write === 1'b1)     cnt_tgt++;
    if (bus.sprite_torpedo_write === 1'b1)    cnt_torp++;
    if (bus.end_of_game_timer_start === 1'b1) cnt_tmr++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic shoot();
    bus.key = 1'b1;
    tick(1);
    bus.key = 1'b0;
    tick(1);
  endtask

  // Timer model: wait for start, run 4 cycles, then wait for the next round or game over.
  task automatic finish_round(input string tag, input logic exp_won, input logic exp_lost);
    int n;
    n = 0;
    while (bus.end_of_game_timer_start !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check({tag, "_timer_start"}, bus.end_of_game_timer_start, 1);
    check({tag, "_round_won"}, bus.round_won, exp_won);
    check({tag, "_round_lost"}, bus.round_lost, exp_lost);
    bus.end_of_game_timer_running = 1'b1;
    tick(4);
    bus.end_of_game_timer_running = 1'b0;
    n = 0;
    while (bus.sprite_target_write !== 1'b1 && bus.game_over !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check({tag, "_round_exit"}, (n < 50), 1);
  endtask

  initial begin
    logic [1:0] exp_score [4];
    exp_score = '{2'd2, 2'd3, 2'd3, 2'd3};
    bus.key = 1'b0;
    bus.sprite_target_out_of_screen = 1'b0;
    bus.sprite_torpedo_out_of_screen = 1'b0;
    bus.collision = 1'b0;
    bus.end_of_game_timer_running = 1'b0;
    reset = 1'b1;
    tick(3);

    check("rst_score", bus.score, 0);
    check("rst_lives", bus.lives, 3);
    check("rst_shots", bus.shots_left, 3);
    check("rst_target_write", bus.sprite_target_write, 0);
    check("rst_torpedo_write", bus.sprite_torpedo_write, 0);
    check("rst_timer_start", bus.end_of_game_timer_start, 0);
    check("rst_status", {bus.round_won, bus.round_lost, bus.game_over}, 0);

    // Round 1: single shot that hits.
    reset = 1'b0;
    c_tgt = cnt_tgt; c_torp = cnt_torp; c_tmr = cnt_tmr;
    tick(10);
    check("t1_target_once", cnt_tgt - c_tgt, 1);
    shoot();
    check("t1_torpedo_once", cnt_torp - c_torp, 1);
    check("t1_shots", bus.shots_left, 2);
    tick(20);
    bus.collision = 1'b1;
    tick(1);
    bus.collision = 1'b0;
    finish_round("t1", 1'b1, 1'b0);
    check("t1_score", bus.score, 1);
    check("t1_lives", bus.lives, 3);
    check("t1_torpedo_total", cnt_torp - c_torp, 1);
    check("t1_timer_total", cnt_tmr - c_tmr, 1);
    check("t1_target_total", cnt_tgt - c_tgt, 2);

    // Round 2: three misses.
    for (int i = 0; i < 3; i++) begin
      shoot();
      check("t2_shots", bus.shots_left, 2 - i);
      tick(3);
      bus.sprite_torpedo_out_of_screen = 1'b1;
      tick(1);
      bus.sprite_torpedo_out_of_screen = 1'b0;
    end
    finish_round("t2", 1'b0, 1'b1);
    check("t2_lives", bus.lives, 2);
    check("t2_shots_reload", bus.shots_left, 3);

    // Rounds 3 and 4: target escapes, game over.
    bus.sprite_target_out_of_screen = 1'b1;
    tick(1);
    bus.sprite_target_out_of_screen = 1'b0;
    finish_round("t3a", 1'b0, 1'b1);
    check("t3a_lives", bus.lives, 1);
    bus.sprite_target_out_of_screen = 1'b1;
    tick(1);
    bus.sprite_target_out_of_screen = 1'b0;
    finish_round("t3b", 1'b0, 1'b1);
    check("t3_game_over", bus.game_over, 1);
    check("t3_lives_zero", bus.lives, 0);
    c_tgt = cnt_tgt;
    tick(10);
    check("t3_game_over_hold", bus.game_over, 1);
    check("t3_no_target", cnt_tgt - c_tgt, 0);
    bus.key = 1'b1;
    tick(2);
    check("t3_restart_target", cnt_tgt - c_tgt, 1);
    check("t3_restart_score", bus.score, 0);
    check("t3_restart_lives", bus.lives, 3);
    check("t3_restart_game_over", bus.game_over, 0);
    bus.key = 1'b0;
    tick(1);

    // Collision coincident with target exit counts as a win.
    shoot();
    tick(2);
    bus.collision = 1'b1;
    bus.sprite_target_out_of_screen = 1'b1;
    tick(1);
    bus.collision = 1'b0;
    bus.sprite_target_out_of_screen = 1'b0;
    finish_round("t4", 1'b1, 1'b0);
    check("t4_score", bus.score, 1);
    check("t4_lives", bus.lives, 3);

    // Score saturation with a 2-bit score.
    for (int i = 0; i < 4; i++) begin
      shoot();
      tick(2);
      bus.collision = 1'b1;
      tick(1);
      bus.collision = 1'b0;
      finish_round("t5", 1'b1, 1'b0);
      check("t5_score", bus.score, exp_score[i]);
    end

    // Held key fires once; reset while a torpedo is in flight.
    c_torp = cnt_torp;
    bus.key = 1'b1;
    tick(100);
    check("t6_held_key_one_torpedo", cnt_torp - c_torp, 1);
    check("t6_shots", bus.shots_left, 2);
    reset = 1'b1;
    tick(1);
    check("t6_rst_score", bus.score, 0);
    check("t6_rst_lives", bus.lives, 3);
    check("t6_rst_shots", bus.shots_left, 3);
    check("t6_rst_pulses", {bus.sprite_target_write, bus.sprite_torpedo_write,
                            bus.end_of_game_timer_start}, 0);
    check("t6_rst_status", {bus.round_won, bus.round_lost, bus.game_over}, 0);
    tick(1);
    reset = 1'b0;
    c_tgt = cnt_tgt; c_torp = cnt_torp;
    tick(6);
    check("t6_post_rst_target", cnt_tgt - c_tgt, 1);
    check("t6_post_rst_no_torpedo", cnt_torp - c_torp, 0);
    bus.key = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
